// File: rtl/data_demux_pkg.sv
// Shared constants for the receive-side frame demultiplexer.
// Frame layout: address, data high, data low, 8-bit wrap-around checksum.
package data_demux_pkg;

    localparam logic [1:0] S_ADDR = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;
    localparam logic [1:0] S_CS   = 2'd3;

    localparam logic [7:0] ADDR_0 = 8'h00;
    localparam logic [7:0] ADDR_1 = 8'h01;

    localparam int FRAME_BYTES = 4;
    localparam int TO_W        = 20;

    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] h,
                                             input logic [7:0] l);
        return a + h + l;
    endfunction

endpackage

// File: rtl/data_demux_strobe_edge.sv
// Rising-edge detector for a receiver byte-valid level.
// pre_strb resets high so a strobe held through reset release is not taken as a new byte.
module strobe_edge (
    input  logic clk,
    input  logic reset,
    input  logic strb,
    output logic accept
);

    logic pre_strb_q, pre_strb_d;

    always_comb pre_strb_d = strb;

    always_ff @(posedge clk) begin
        if (!reset) pre_strb_q <= 1'b1;
        else        pre_strb_q <= pre_strb_d;
    end

    assign accept = strb & ~pre_strb_q;

endmodule

// File: rtl/data_demux.sv
// Parses 4-byte frames and writes {hi,lo} to data_out_0/1 selected by the address byte.
// Define DATA_DEMUX_TIMEOUT_EN to abandon a partial frame after TIMEOUT_CYCLES idle cycles.
module data_demux
    import data_demux_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_strb,
    output logic [15:0] data_out_0,
    output logic [15:0] data_out_1,
    output logic        upd_0,
    output logic        upd_1,
    output logic        frame_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << TO_W) - 1) begin : g_bad_timeout
        $error("data_demux: TIMEOUT_CYCLES out of range");
    end

    logic        accept;
    logic        timeout_hit;
    logic [1:0]  state_q, state_d;
    logic [7:0]  addr_q, addr_d, hi_q, hi_d, lo_q, lo_d;
    logic [15:0] data0_q, data0_d, data1_q, data1_d;
    logic        upd0_q, upd0_d, upd1_q, upd1_d, err_q, err_d;

    strobe_edge u_strobe_edge (
        .clk    (clk),
        .reset  (reset),
        .strb   (rx_strb),
        .accept (accept)
    );

`ifdef DATA_DEMUX_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        timeout_hit = 1'b0;
        cnt_d       = cnt_q + 1'b1;
        if (accept || state_q == S_ADDR) begin
            cnt_d = '0;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        data0_d = data0_q;
        data1_d = data1_q;
        upd0_d  = 1'b0;
        upd1_d  = 1'b0;
        err_d   = 1'b0;
        // An accept on the expiry edge takes priority over the timeout.
        if (accept) begin
            case (state_q)
                S_ADDR: begin addr_d = rx_data; state_d = S_HI; end
                S_HI:   begin hi_d   = rx_data; state_d = S_LO; end
                S_LO:   begin lo_d   = rx_data; state_d = S_CS; end
                default: begin
                    state_d = S_ADDR;
                    if (rx_data == frame_sum(addr_q, hi_q, lo_q)) begin
                        if (addr_q == ADDR_0) begin
                            data0_d = {hi_q, lo_q};
                            upd0_d  = 1'b1;
                        end else if (addr_q == ADDR_1) begin
                            data1_d = {hi_q, lo_q};
                            upd1_d  = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end else if (timeout_hit) begin
            state_d = S_ADDR;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_ADDR;
            addr_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            data0_q <= '0;
            data1_q <= '0;
            upd0_q  <= 1'b0;
            upd1_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            upd0_q  <= upd0_d;
            upd1_q  <= upd1_d;
            err_q   <= err_d;
        end
    end

    assign data_out_0 = data0_q;
    assign data_out_1 = data1_q;
    assign upd_0      = upd0_q;
    assign upd_1      = upd1_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_data_demux.sv
// Randomized bench for data_demux against a queue-based frame model, plus directed frames.
module tb_data_demux;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_strb = 1'b0;
    logic [15:0] data_out_0, data_out_1;
    logic        upd_0, upd_1, frame_err;

    data_demux #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_strb    (rx_strb),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .upd_0      (upd_0),
        .upd_1      (upd_1),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: bytes of the current frame are collected in a queue.
    bit          started = 0;
    bit          m_prev = 1;
    int          fq[$];
    int          since = 0;
    logic [15:0] e_d0 = '0, e_d1 = '0;
    logic        e_u0 = 0, e_u1 = 0, e_err = 0;

    always @(posedge clk) begin
        bit acc;
        started = 1;
        e_u0 = 0; e_u1 = 0; e_err = 0;
        if (!reset) begin
            m_prev = 1; fq.delete(); since = 0; e_d0 = '0; e_d1 = '0;
        end else begin
            acc = rx_strb && !m_prev;
            m_prev = rx_strb;
            if (acc) begin
                fq.push_back(int'(rx_data));
                since = 0;
                if (fq.size() == 4) begin
                    if (((fq[0] + fq[1] + fq[2]) % 256) == fq[3]) begin
                        if (fq[0] == 0) begin e_d0 = 16'(fq[1] * 256 + fq[2]); e_u0 = 1; end
                        else if (fq[0] == 1) begin e_d1 = 16'(fq[1] * 256 + fq[2]); e_u1 = 1; end
                    end else e_err = 1;
                    fq.delete();
                end
            end else if (fq.size() > 0) begin
`ifdef DATA_DEMUX_TIMEOUT_EN
                since++;
                if (since == TO) begin e_err = 1; fq.delete(); since = 0; end
`endif
            end
        end
    end

    int c_u0 = 0, c_u1 = 0, c_err = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("data_out_0", 32'(data_out_0), 32'(e_d0));
            chk("data_out_1", 32'(data_out_1), 32'(e_d1));
            chk("upd_0", 32'(upd_0), 32'(e_u0));
            chk("upd_1", 32'(upd_1), 32'(e_u1));
            chk("frame_err", 32'(frame_err), 32'(e_err));
            if (upd_0 === 1'b1) c_u0++;
            if (upd_1 === 1'b1) c_u1++;
            if (frame_err === 1'b1) c_err++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hi_w, input int lo_w);
        rx_data = b;
        rx_strb = 1'b1;
        repeat (hi_w) @(negedge clk);
        rx_strb = 1'b0;
        repeat (lo_w) @(negedge clk);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                         input logic [7:0] c);
        send_byte(a, 1, 1); send_byte(h, 1, 1); send_byte(l, 1, 1); send_byte(c, 1, 1);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    int u0_0, u1_0, err_0;

    task automatic snap();
        u0_0 = c_u0; u1_0 = c_u1; err_0 = c_err;
    endtask

    task automatic do_reset(input logic strb_level, input int cycles);
        reset = 1'b0;
        rx_strb = strb_level;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset data_out_0", 32'(data_out_0), 32'h0);
        chk("reset data_out_1", 32'(data_out_1), 32'h0);
        chk("reset pulses", 32'({upd_0, upd_1, frame_err}), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        snap();
        send4(8'h01, 8'h12, 8'h34, 8'h47); settle();
        chk("t1 data_out_1", 32'(data_out_1), 32'h1234);
        chk("t1 upd_1 count", 32'(c_u1 - u1_0), 32'd1);
        chk("t1 data_out_0", 32'(data_out_0), 32'h0);
        chk("t1 err count", 32'(c_err - err_0), 32'd0);

        snap();
        send4(8'h00, 8'hFF, 8'h02, 8'h01); settle();
        chk("t2 data_out_0", 32'(data_out_0), 32'hFF02);
        chk("t2 upd_0 count", 32'(c_u0 - u0_0), 32'd1);

        snap();
        send4(8'h01, 8'hAB, 8'hCD, 8'h00); settle();
        chk("t3 err count", 32'(c_err - err_0), 32'd1);
        chk("t3 data_out_1 held", 32'(data_out_1), 32'h1234);
        send4(8'h01, 8'h00, 8'h05, 8'h06); settle();
        chk("t3 data_out_1 next", 32'(data_out_1), 32'h0005);

        snap();
        send4(8'h07, 8'h11, 8'h22, 8'h3A); settle();
        chk("t4 no upd", 32'((c_u0 - u0_0) + (c_u1 - u1_0)), 32'd0);
        chk("t4 no err", 32'(c_err - err_0), 32'd0);
        send4(8'h00, 8'h12, 8'h34, 8'h46); settle();
        chk("t4 data_out_0 next", 32'(data_out_0), 32'h1234);

        snap();
        send_byte(8'h01, 1, 1); send_byte(8'h12, 1, 1);
        repeat (20) @(negedge clk);
        #1;
`ifdef DATA_DEMUX_TIMEOUT_EN
        chk("t5 timeout err count", 32'(c_err - err_0), 32'd1);
`else
        chk("t5 no timeout err", 32'(c_err - err_0), 32'd0);
        do_reset(1'b0, 2);
        @(negedge clk);
`endif
        send4(8'h00, 8'h00, 8'h01, 8'h01); settle();
        chk("t5 data_out_0", 32'(data_out_0), 32'h0001);

        // Second byte accepted exactly TO edges after the first one.
        snap();
        send_byte(8'h01, 1, 1);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h12, 1, 1);
        send_byte(8'h34, 1, 1); send_byte(8'h47, 1, 1); settle();
        chk("t6 expiry no err", 32'(c_err - err_0), 32'd0);
        chk("t6 data_out_1", 32'(data_out_1), 32'h1234);

        send_byte(8'h01, 1, 1); send_byte(8'h12, 1, 1);
        @(negedge clk);
        do_reset(1'b1, 2);
        repeat (3) @(negedge clk);
        #1;
        chk("t7 data_out_0 reset", 32'(data_out_0), 32'h0);
        chk("t7 data_out_1 reset", 32'(data_out_1), 32'h0);
        rx_strb = 1'b0;
        @(negedge clk);
        send4(8'h01, 8'h12, 8'h34, 8'h47); settle();
        chk("t7 data_out_1", 32'(data_out_1), 32'h1234);

        for (int f = 0; f < 150; f++) begin
            logic [7:0] bytes [4];
            int sel = $urandom_range(0, 9);
            bytes[0] = (sel < 4) ? 8'h00 : (sel < 8) ? 8'h01 : 8'($urandom);
            bytes[1] = 8'($urandom);
            bytes[2] = 8'($urandom);
            bytes[3] = bytes[0] + bytes[1] + bytes[2];
            if ($urandom_range(0, 5) == 0) bytes[3] = bytes[3] + 8'($urandom_range(1, 255));
            for (int i = 0; i < 4; i++) begin
                send_byte(bytes[i], $urandom_range(1, 3), $urandom_range(1, 3));
                if ($urandom_range(0, 11) == 0) repeat ($urandom_range(8, 25)) @(negedge clk);
                if ($urandom_range(0, 30) == 0) begin
                    do_reset(1'($urandom), $urandom_range(1, 3));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    rx_strb = 1'b0;
                    @(negedge clk);
                end
            end
        end
        repeat (4) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_demux.md
Name: data_demux

Overview:
Receive-side counterpart of the transmit data selector.
- Parses 4-byte frames from the serial byte receiver: address, data high, data low, checksum.
- On a valid frame, writes the 16-bit word into the output register selected by the address, and pulses that register's update strobe.
- Sits between the byte receiver and the downstream consumers of data_0/data_1.

Parameters:
- TIMEOUT_CYCLES, 50000: maximum allowed clk cycles between accepted bytes inside a frame. Range 2..2^20-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- rx_data  in  8  received byte, stable while rx_strb is high.
- rx_strb  in  1  byte-valid level from the receiver; only its rising edge is used.
- data_out_0  out  16  register for address 0x00.
- data_out_1  out  16  register for address 0x01.
- upd_0  out  1  one-cycle pulse when data_out_0 is written.
- upd_1  out  1  one-cycle pulse when data_out_1 is written.
- frame_err  out  1  one-cycle pulse on checksum mismatch or timeout.

Behaviour:
- Reset (reset=0 at a clk edge):
  - data_out_0/1 = 16'h0000; upd_0, upd_1, frame_err = 0.
  - State = S_ADDR, timeout counter = 0, internal bytes = 0.
  - Edge-detect register pre_strb = 1, so a strobe held high through reset release is not accepted.
  - Reset mid-frame discards the partial frame.
- Byte accept: at a clk edge where rx_strb=1 and pre_strb=0. pre_strb <= rx_strb every cycle outside reset.
- FSM, advancing only on byte accept:
  - S_ADDR: store addr, go to S_HI.
  - S_HI: store hi, go to S_LO.
  - S_LO: store lo, go to S_CS.
  - S_CS: check the byte, then go to S_ADDR.
- Checksum rule: cs == (addr + hi + lo) mod 256, computed as an 8-bit wrap-around sum.
- Frame result, registered at the same edge that accepts the checksum byte (visible the next cycle, latency 1 from the accept edge):
  - Match, addr=0x00: data_out_0 <= {hi,lo}; upd_0 = 1 for one cycle.
  - Match, addr=0x01: data_out_1 <= {hi,lo}; upd_1 = 1 for one cycle.
  - Match, any other addr: no write, no pulse, no error.
  - Mismatch: no write; frame_err = 1 for one cycle.
- All pulses deassert the following cycle unless retriggered. Outputs hold their value between frames.
- Back-to-back frames are supported with no dead cycles, since an accept only needs an rx_strb low gap of at least one cycle.
- Timeout (see Optional Feature):
  - The 20-bit counter clears on every byte accept and while in S_ADDR, and increments each cycle otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no accept in that cycle: state = S_ADDR, frame_err pulse, counter cleared.
  - If a byte accept and timeout expiry fall on the same edge, the accept wins: no error, the FSM advances, the counter clears.
- rx_data is sampled only on accept edges; values at other times are ignored.

Optional Feature:
- Macro DATA_DEMUX_TIMEOUT_EN.
- Defined: the inter-byte timeout above is implemented.
- Undefined: no counter is synthesised. A partial frame waits indefinitely, frame_err is raised only on checksum mismatch, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package data_demux_pkg holds:
  - State enum/localparams S_ADDR=2'd0, S_HI=2'd1, S_LO=2'd2, S_CS=2'd3.
  - ADDR_0=8'h00, ADDR_1=8'h01.
  - FRAME_BYTES=4.
  - Timeout counter width TO_W=20.
- One natural sub-module: strobe_edge. It holds pre_strb (reset value 1) and emits a single-cycle accept pulse. It is reusable for the transmit selector's lock strobe.
- FSM, checksum and output registers stay in data_demux.

Test Plan:
- Valid frame to address 1: bytes 01,12,34,47 -> data_out_1=16'h1234 one cycle after the 4th accept, upd_1 pulses once, data_out_0 stays 0000, frame_err stays 0.
- Valid frame to address 0 with checksum wrap: bytes 00,FF,02,01 -> data_out_0=16'hFF02, upd_0 pulses once.
- Bad checksum: bytes 01,AB,CD,00 -> frame_err pulses once, data_out_1 unchanged. A following valid frame 01,00,05,06 then writes 0005.
- Unknown address: bytes 07,11,22,3A -> no write, no upd, no frame_err. The next valid frame is parsed correctly.
- Timeout (TIMEOUT_EN, TIMEOUT_CYCLES=16): send 01,12, then idle 20 cycles -> frame_err pulses exactly once. Then 00,00,01,01 -> data_out_0=0001. Also send a byte exactly on the expiry cycle -> no error, FSM advances.
- Reset mid-frame plus held strobe: send 01,12, assert reset=0 for 2 cycles with rx_strb held high, release -> outputs 0. The held strobe is not accepted. The next full frame 01,12,34,47 writes data_out_1=1234.
